hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 40 ++++
 rtl/hazard_md_cnt.sv | 35 +++
 rtl/hazard_ctrl.sv | 71 +++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the hazard controller.
// The MD timing model is only used when HAZARD_MD_UNIT_EN is defined.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } slot_t;

  function automatic logic [1:0] tnew_dec(
    input logic [1:0] t
  );
    return (t == TNEW_PC8) ? TNEW_PC8 : t - 2'd1;
  endfunction

  function automatic logic src_hz(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input slot_t      e,
    input slot_t      m
  );
    logic e_hit;
    logic m_hit;
    e_hit = (e.a3 == r) && (tuse < e.tnew);
    m_hit = (m.a3 == r) && (tuse < m.tnew);
    return (r != 5'd0) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/hazard_md_cnt.sv
// Multiply/divide occupancy counter.
// Loads the op latency on an accepted start, then counts down to idle.
module hazard_md_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? MD_DIV_CYC : MD_MULT_CYC;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generator using Tuse/Tnew shadow slots for E and M.
// Define HAZARD_MD_UNIT_EN to add the multiply/divide busy interlock.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic       flush_E,
  output logic       md_busy
);

  slot_t e_q;
  slot_t e_d;
  slot_t m_q;
  slot_t m_d;
  logic  rs_hz;
  logic  rt_hz;
  logic  md_hz;

  always_comb begin
    rs_hz   = src_hz(rs_D, tuse_rs_D, e_q, m_q);
    rt_hz   = src_hz(rt_D, tuse_rt_D, e_q, m_q);
    stall   = rs_hz | rt_hz | md_hz;
    flush_E = stall;
    e_d     = '0;
    if (!stall) begin
      e_d = '{a3: A3_D, tnew: tnew_D};
    end
    m_d = '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

`ifdef HAZARD_MD_UNIT_EN
  // stall gates the start so a blocked MD op is not launched twice
  hazard_md_cnt u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start_D & ~stall),
    .div_i   (md_div_D),
    .busy_o  (md_busy)
  );

  assign md_hz = md_use_D & md_busy;
`else
  logic unused_md;

  assign unused_md = ^{md_start_D, md_div_D, md_use_D};
  assign md_busy   = 1'b0;
  assign md_hz     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, MD sequences,
// and random traffic against a producer-timeline model.
module tb_hazard_ctrl;

`ifdef HAZARD_MD_UNIT_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] tuse_rs_D;
  logic [1:0] tuse_rt_D;
  logic [4:0] A3_D;
  logic [1:0] tnew_D;
  logic       md_start_D;
  logic       md_div_D;
  logic       md_use_D;
  logic       stall;
  logic       flush_E;
  logic       md_busy;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .A3_D       (A3_D),
    .tnew_D     (tnew_D),
    .md_start_D (md_start_D),
    .md_div_D   (md_div_D),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .flush_E    (flush_E),
    .md_busy    (md_busy)
  );

  typedef struct {
    logic       reset;
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
    logic       md_use;
    logic       exp_stall;
  } vec_t;

  // A producer issued from D in cycle c has its result at cycle c+1+tnew
  typedef struct {
    logic [4:0] a3;
    int         ready;
    int         cyc;
  } prod_t;

  prod_t prods[$];
  int    cyc = 0;
  int    md_end = -1;
  int    n_tests = 0;
  int    n_fail = 0;

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [1:0] trs,
    input logic [4:0] rt, input logic [1:0] trt,
    input logic [4:0] a3, input logic [1:0] tn,
    input logic es
  );
    vec_t v;
    v.reset = 1'b0;
    v.rs = rs; v.tuse_rs = trs;
    v.rt = rt; v.tuse_rt = trt;
    v.a3 = a3; v.tnew = tn;
    v.md_start = 1'b0; v.md_div = 1'b0; v.md_use = 1'b0;
    v.exp_stall = es;
    return v;
  endfunction

  function automatic bit m_src(input logic [4:0] r, input logic [1:0] tu);
    if (r == 5'd0) return 1'b0;
    foreach (prods[i]) begin
      if (prods[i].a3 == r && prods[i].cyc >= cyc - 2 &&
          cyc + int'(tu) < prods[i].ready) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return MD_EN && (cyc <= md_end);
  endfunction

  function automatic bit m_stall(input vec_t v);
    return m_src(v.rs, v.tuse_rs) | m_src(v.rt, v.tuse_rt) |
           (MD_EN && v.md_use && m_busy());
  endfunction

  task automatic m_step(input vec_t v, input bit st);
    if (v.reset) begin
      prods.delete();
      md_end = -1;
    end else if (!st) begin
      prods.push_back('{a3: v.a3, ready: cyc + 1 + int'(v.tnew), cyc: cyc});
      if (MD_EN && v.md_start) md_end = cyc + (v.md_div ? 10 : 5);
    end
    cyc++;
    while (prods.size() > 0 && prods[0].cyc < cyc - 2) void'(prods.pop_front());
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit es, input bit eb, input string nm);
    bit ms;
    ms = m_stall(v);
    reset = v.reset;
    rs_D = v.rs; tuse_rs_D = v.tuse_rs;
    rt_D = v.rt; tuse_rt_D = v.tuse_rt;
    A3_D = v.a3; tnew_D = v.tnew;
    md_start_D = v.md_start; md_div_D = v.md_div; md_use_D = v.md_use;
    @(negedge clk);
    chk({nm, ".stall"}, stall, es);
    chk({nm, ".flush_E"}, flush_E, es);
    chk({nm, ".md_busy"}, md_busy, eb);
    @(posedge clk);
    m_step(v, ms);
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  vec_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    rs_D = '0; rt_D = '0; tuse_rs_D = '0; tuse_rt_D = '0;
    A3_D = '0; tnew_D = '0;
    md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply(nop, 1'b0, 1'b0, "reset_state");

    // load-use
    tbl.push_back(mk(0, 0, 0, 0, 8, 2, 0));
    tbl.push_back(mk(8, 1, 0, 1, 10, 1, 1));
    tbl.push_back(mk(8, 1, 0, 1, 10, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    // branch after ALU
    tbl.push_back(mk(0, 0, 0, 0, 9, 1, 0));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0));
    // branch after load
    tbl.push_back(mk(0, 0, 0, 0, 9, 2, 0));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0));
    // register zero
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0));
    // rt load-use, jal/jr, rt from M
    tbl.push_back(mk(0, 0, 0, 0, 7, 2, 0));
    tbl.push_back(mk(3, 1, 7, 1, 4, 1, 1));
    tbl.push_back(mk(3, 1, 7, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 31, 0, 0));
    tbl.push_back(mk(31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 5, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 5, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i], tbl[i].exp_stall, 1'b0, $sformatf("tbl%0d", i));
    end

    // divide then mflo
    v = nop; v.md_start = 1'b1; v.md_div = 1'b1; v.md_use = 1'b1;
    apply(v, 1'b0, 1'b0, "div_start");
    v = mk(0, 0, 0, 0, 2, 1, 0); v.md_use = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(v, MD_EN, MD_EN, $sformatf("mflo_wait%0d", i));
    end
    apply(v, 1'b0, 1'b0, "mflo_go");
    apply(nop, 1'b0, 1'b0, "div_idle");

    // reset in the middle of a mult, with a load still in flight
    v = nop; v.md_start = 1'b1; v.md_use = 1'b1;
    apply(v, 1'b0, 1'b0, "mult_start");
    apply(nop, 1'b0, MD_EN, "mult_c1");
    apply(mk(0, 0, 0, 0, 8, 2, 0), 1'b0, MD_EN, "mult_c2");
    v = nop; v.reset = 1'b1;
    apply(v, 1'b0, MD_EN, "mult_rst");
    v = mk(8, 0, 0, 0, 0, 0, 0); v.md_use = 1'b1;
    apply(v, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 600; i++) begin
      v.reset    = ($urandom_range(0, 49) == 0);
      v.rs       = 5'($urandom_range(0, 7));
      v.rt       = 5'($urandom_range(0, 7));
      v.tuse_rs  = 2'($urandom_range(0, 2));
      v.tuse_rt  = 2'($urandom_range(0, 2));
      v.a3       = 5'($urandom_range(0, 7));
      v.tnew     = 2'($urandom_range(0, 2));
      v.md_start = ($urandom_range(0, 9) == 0);
      v.md_div   = 1'($urandom);
      v.md_use   = v.md_start | ($urandom_range(0, 3) == 0);
      apply(v, m_stall(v), m_busy(), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
